// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding and a sizing helper used for elaboration checks.
package bin_to_bcd_pkg;

  // Controller states: waiting for work, shifting bits in, presenting result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Minimum number of decimal digits needed to hold any WIDTH-bit unsigned
  // value: ceil(width * log10(2)). log10(2) is approximated as 0.30103, which
  // is exact enough for any practical width (the error stays far below one
  // digit for widths well beyond 10^4 bits).
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Inputs above 9 never occur on a legal BCD digit; the +3 wraps harmlessly.
  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). A start pulse while
// idle captures bin_in; WIDTH shift cycles later the packed BCD result and an
// overflow flag are registered and announced by a one-cycle done pulse.
// When the value does not fit in DIGITS digits, the result is the value
// modulo 10^DIGITS and overflow is set.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time sanity checks on the parameter set.
  if (WIDTH < 1) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be at least 1 (got %0d)", WIDTH);
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS must be at least 1 (got %0d)", DIGITS);
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_ovf_possible
    $info("bin_to_bcd_seq: warning, DIGITS=%0d is below the %0d needed for WIDTH=%0d; overflow is possible",
          DIGITS, min_digits(WIDTH), WIDTH);
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_acc;
  logic [SR_W-1:0]   r_sr;

  logic [BCD_W-1:0]  w_adj;
  logic [SR_W-1:0]   w_sr_next;
  logic              w_carry;
  logic              w_accept;
  logic              w_last;

  // Per-digit add-3 correction on the BCD half of the shift register; all
  // digits are corrected independently in the same cycle as the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_sr[WIDTH + 4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is a carry worth 10^DIGITS: it is dropped
  // from the register (keeping the lower digits exact modulo 10^DIGITS) and
  // recorded as overflow.
  assign w_carry   = w_adj[BCD_W-1];
  assign w_sr_next = {w_adj[BCD_W-2:0], r_sr[WIDTH-1:0], 1'b0};

  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_cnt == CNT_ONE);

  // Shift register datapath: load on accepted start, shift while converting.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sr <= {{BCD_W{1'b0}}, bin_in};
    end else if (r_state == SHIFT) begin
      r_sr <= w_sr_next;
    end
  end

  // Controller with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_cnt     <= CNT_LOAD;
            r_ovf_acc <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_cnt     <= r_cnt - CNT_ONE;
          r_ovf_acc <= r_ovf_acc | w_carry;
          if (w_last) begin
            bcd_out  <= w_sr_next[SR_W-1 -: BCD_W];
            overflow <= r_ovf_acc | w_carry;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance of the
// 8-bit converter share clock and reset.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, ready_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;

  logic        start_b, ready_b, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;

  int total = 0;
  int bad   = 0;
  int dn_a  = 0;
  int dn_b  = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .ready(ready_a), .busy(busy_a), .done(done_a),
    .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .ready(ready_b), .busy(busy_b), .done(done_b),
    .bcd_out(bcd_b), .overflow(ovf_b)
  );

  // done is high for whole cycles, so each pulse is seen at exactly one negedge
  always @(negedge clk) begin
    if (done_a === 1'b1) dn_a++;
    if (done_b === 1'b1) dn_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected instance shows done; n = edges taken.
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!((sel ? done_b : done_a) === 1'b1) && n < 40);
  endtask

  // One conversion on the 3-digit instance with start pulsed for one cycle.
  task automatic run_a(input string tag, input logic [7:0] v, input logic [11:0] exp_bcd);
    int n;
    start_a = 1'b1;
    bin_a   = v;
    step();
    start_a = 1'b0;
    chk({tag, "_busy"}, 32'(busy_a), 32'd1);
    wait_done(1'b0, n);
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_bcd"}, 32'(bcd_a), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(ovf_a), 32'd0);
    step();
    chk({tag, "_done_off"}, 32'(done_a), 32'd0);
    chk({tag, "_ready"}, 32'(ready_a), 32'd1);
  endtask

  // One conversion on the 2-digit instance.
  task automatic run_b(input string tag, input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf);
    int n;
    start_b = 1'b1;
    bin_b   = v;
    step();
    start_b = 1'b0;
    wait_done(1'b1, n);
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_bcd"}, 32'(bcd_b), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(ovf_b), 32'(exp_ovf));
    step();
  endtask

  initial begin
    int n;
    int snap;
    rst = 1'b1;
    start_a = 1'b0; bin_a = '0;
    start_b = 1'b0; bin_b = '0;
    repeat (3) step();

    // Reset state
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_bcd",   32'(bcd_a),   32'd0);
    chk("rst_ovf",   32'(ovf_a),   32'd0);
    rst = 1'b0;
    step();

    // Main function, 3 digits
    run_a("v255", 8'd255, 12'h255);
    run_a("v0",   8'd0,   12'h000);
    run_a("v9",   8'd9,   12'h009);
    run_a("v10",  8'd10,  12'h010);

    // Two digits: overflow and largest fitting value
    run_b("b150", 8'd150, 8'h50, 1'b1);
    run_b("b99",  8'd99,  8'h99, 1'b0);

    // start held during SHIFT with a changing operand is ignored
    snap    = dn_a;
    start_a = 1'b1;
    bin_a   = 8'd77;
    step();
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin
      bin_a = 8'($urandom_range(0, 255));
      step();
      n++;
    end
    start_a = 1'b0;
    chk("ign_lat", 32'(n), 32'd8);
    chk("ign_bcd", 32'(bcd_a), 32'h077);
    repeat (4) step();
    chk("ign_pulses", 32'(dn_a - snap), 32'd1);
    chk("ign_hold", 32'(bcd_a), 32'h077);

    // Reset during the 4th SHIFT cycle abandons the conversion
    snap    = dn_a;
    start_a = 1'b1;
    bin_a   = 8'd200;
    step();
    start_a = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_ready", 32'(ready_a), 32'd1);
    chk("mid_busy",  32'(busy_a),  32'd0);
    chk("mid_bcd",   32'(bcd_a),   32'd0);
    chk("mid_done",  32'(done_a),  32'd0);
    repeat (12) step();
    chk("mid_nopulse", 32'(dn_a - snap), 32'd0);
    run_a("v42", 8'd42, 12'h042);

    // Back-to-back with start held high
    start_a = 1'b1;
    bin_a   = 8'd123;
    wait_done(1'b0, n);
    chk("b2b_first_lat", 32'(n), 32'd9);
    chk("b2b_first_bcd", 32'(bcd_a), 32'h123);
    chk("b2b_done_ready", 32'(ready_a), 32'd0);
    bin_a = 8'd200;
    wait_done(1'b0, n);
    start_a = 1'b0;
    chk("b2b_spacing", 32'(n), 32'd10);
    chk("b2b_second_bcd", 32'(bcd_a), 32'h200);
    chk("b2b_second_ovf", 32'(ovf_a), 32'd0);
    repeat (3) step();
    chk("b2b_idle", 32'(ready_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
